// File: rtl/stack_cache.sv
// stack_cache: data-stack front end for the fomu CPU.
// Keeps the top two stack items (TOS, NOS) in registers and spills deeper
// items to / refills them from an external single-ended LIFO (lifo_se).
// One stack op per cycle; CLEAR drains the LIFO over several cycles.
//
// Ports:
//   i_clk, i_rst            clock (rising edge), async active-high reset
//   i_se, i_op, i_data      op strobe, op code, operand (PUSH / REPLACE)
//   o_ready                 high when a new op can be accepted
//   o_tos, o_nos, o_depth   registered top / next items and total item count
//   o_err                   sticky underflow / overflow flag
//   o_lifo_push/pop/data    LIFO strobes (push+pop = replace top) and data
//   i_lifo_data/empty/full  LIFO top item and status
//
// state | meaning
// READY | accepting one op per cycle
// DRAIN | CLEAR in progress, popping the LIFO until it reports empty
module stack_cache #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 12
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_se,
  input  logic [2:0]                   i_op,
  input  logic [WIDTH-1:0]             i_data,
  output logic                         o_ready,
  output logic [WIDTH-1:0]             o_tos,
  output logic [WIDTH-1:0]             o_nos,
  output logic [$clog2(DEPTH+3)-1:0]   o_depth,
  output logic                         o_err,
  output logic                         o_lifo_push,
  output logic                         o_lifo_pop,
  output logic [WIDTH-1:0]             o_lifo_data,
  input  logic [WIDTH-1:0]             i_lifo_data,
  input  logic                         i_lifo_empty,
  input  logic                         i_lifo_full
);

  localparam int DW = $clog2(DEPTH+3);
  localparam logic [DW-1:0] CAP = DW'(DEPTH+2);
  localparam logic [DW-1:0] D0  = '0;
  localparam logic [DW-1:0] D1  = DW'(1);
  localparam logic [DW-1:0] D2  = DW'(2);
  localparam logic [DW-1:0] D3  = DW'(3);

  localparam logic [2:0] OP_CLEAR   = 3'd0;
  localparam logic [2:0] OP_PUSH    = 3'd1;
  localparam logic [2:0] OP_DROP    = 3'd2;
  localparam logic [2:0] OP_DUP     = 3'd3;
  localparam logic [2:0] OP_SWAP    = 3'd4;
  localparam logic [2:0] OP_OVER    = 3'd5;
  localparam logic [2:0] OP_ROT     = 3'd6;
  localparam logic [2:0] OP_REPLACE = 3'd7;

  typedef enum logic {READY = 1'b0, DRAIN = 1'b1} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] tos, tos_n, nos, nos_n;
  logic [DW-1:0]    depth, depth_n;
  logic             err, err_n;
  logic             accept;
  logic             room;
  logic [WIDTH-1:0] push_val;
  logic             push_legal;

  assign accept = (state == READY) && i_se;
  assign room   = (depth < CAP);

  // state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= READY;
    else       state <= state_n;
  end

  // next-state logic
  always_comb begin
    state_n = state;
    case (state)
      READY: if (accept && (i_op == OP_CLEAR) && !i_lifo_empty) state_n = DRAIN;
      DRAIN: if (i_lifo_empty) state_n = READY;
      default: state_n = READY;
    endcase
  end

  // PUSH, DUP and OVER share one path differing only in the value pushed
  always_comb begin
    push_val = i_data;
    if (i_op == OP_DUP)  push_val = tos;
    if (i_op == OP_OVER) push_val = nos;
  end

  always_comb begin
    push_legal = room;
    if (i_op == OP_DUP)  push_legal = room && (depth >= D1);
    if (i_op == OP_OVER) push_legal = room && (depth >= D2);
  end

  // output / datapath logic
  always_comb begin
    tos_n       = tos;
    nos_n       = nos;
    depth_n     = depth;
    err_n       = err;
    o_lifo_push = 1'b0;
    o_lifo_pop  = 1'b0;
    o_ready     = (state == READY);
    case (state)
      READY: begin
        if (accept) begin
          case (i_op)
            OP_CLEAR: begin
              tos_n = '0;
              nos_n = '0;
              err_n = 1'b0;
              if (i_lifo_empty) depth_n = D0;
              else              o_lifo_pop = 1'b1;
            end
            OP_PUSH, OP_DUP, OP_OVER: begin
              if (!push_legal) begin
                err_n = 1'b1;
              end else if ((depth >= D2) && i_lifo_full) begin
                // depth tracking disagrees with the LIFO; refuse the spill
                err_n = 1'b1;
              end else begin
                tos_n       = push_val;
                nos_n       = tos;
                depth_n     = depth + D1;
                o_lifo_push = (depth >= D2);
              end
            end
            OP_DROP: begin
              if (depth == D0) begin
                err_n = 1'b1;
              end else begin
                tos_n   = nos;
                depth_n = depth - D1;
                if (depth >= D3) begin
                  nos_n      = i_lifo_data;
                  o_lifo_pop = 1'b1;
                end else begin
                  nos_n = '0;
                end
              end
            end
            OP_SWAP: begin
              if (depth < D2) begin
                err_n = 1'b1;
              end else begin
                tos_n = nos;
                nos_n = tos;
              end
            end
            OP_ROT: begin
              if (depth < D3) begin
                err_n = 1'b1;
              end else begin
                // replace LIFO top: old NOS goes down, old third item comes up
                tos_n       = i_lifo_data;
                nos_n       = tos;
                o_lifo_push = 1'b1;
                o_lifo_pop  = 1'b1;
              end
            end
            OP_REPLACE: begin
              if (depth == D0) err_n = 1'b1;
              else             tos_n = i_data;
            end
            default: err_n = 1'b1;
          endcase
        end
      end
      DRAIN: begin
        if (i_lifo_empty) depth_n = D0;
        else              o_lifo_pop = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tos   <= '0;
      nos   <= '0;
      depth <= '0;
      err   <= 1'b0;
    end else begin
      tos   <= tos_n;
      nos   <= nos_n;
      depth <= depth_n;
      err   <= err_n;
    end
  end

  assign o_tos       = tos;
  assign o_nos       = nos;
  assign o_depth     = depth;
  assign o_err       = err;
  assign o_lifo_data = nos;

endmodule

// File: tb/tb_stack_cache.sv
module tb_stack_cache;
  localparam int WIDTH = 16;
  localparam int DEPTH = 12;
  localparam int DW    = $clog2(DEPTH+3);

  localparam logic [2:0] OP_CLEAR   = 3'd0;
  localparam logic [2:0] OP_PUSH    = 3'd1;
  localparam logic [2:0] OP_DROP    = 3'd2;
  localparam logic [2:0] OP_DUP     = 3'd3;
  localparam logic [2:0] OP_SWAP    = 3'd4;
  localparam logic [2:0] OP_OVER    = 3'd5;
  localparam logic [2:0] OP_ROT     = 3'd6;
  localparam logic [2:0] OP_REPLACE = 3'd7;

  logic             i_clk = 1'b0;
  logic             i_rst = 1'b1;
  logic             i_se = 1'b0;
  logic [2:0]       i_op = 3'd0;
  logic [WIDTH-1:0] i_data = '0;
  logic             o_ready;
  logic [WIDTH-1:0] o_tos, o_nos;
  logic [DW-1:0]    o_depth;
  logic             o_err;
  logic             o_lifo_push, o_lifo_pop;
  logic [WIDTH-1:0] o_lifo_data;
  logic [WIDTH-1:0] i_lifo_data;
  logic             i_lifo_empty, i_lifo_full;

  int total = 0;
  int bad   = 0;

  stack_cache #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_se(i_se), .i_op(i_op), .i_data(i_data),
    .o_ready(o_ready), .o_tos(o_tos), .o_nos(o_nos), .o_depth(o_depth),
    .o_err(o_err), .o_lifo_push(o_lifo_push), .o_lifo_pop(o_lifo_pop),
    .o_lifo_data(o_lifo_data), .i_lifo_data(i_lifo_data),
    .i_lifo_empty(i_lifo_empty), .i_lifo_full(i_lifo_full)
  );

  always #5 i_clk = ~i_clk;

  // behavioural single-ended LIFO sharing the reset
  logic [WIDTH-1:0] lmem [DEPTH];
  int lcnt;
  always @(posedge i_clk or posedge i_rst) begin
    if (i_rst) lcnt <= 0;
    else if (o_lifo_push && o_lifo_pop) begin
      if (lcnt > 0) lmem[lcnt-1] <= o_lifo_data;
    end else if (o_lifo_push) begin
      if (lcnt < DEPTH) begin
        lmem[lcnt] <= o_lifo_data;
        lcnt <= lcnt + 1;
      end
    end else if (o_lifo_pop) begin
      if (lcnt > 0) lcnt <= lcnt - 1;
    end
  end
  always_comb begin
    i_lifo_data = '0;
    if (lcnt > 0) i_lifo_data = lmem[lcnt-1];
  end
  assign i_lifo_empty = (lcnt == 0);
  assign i_lifo_full  = (lcnt == DEPTH);

  task automatic chk(input string name, input int tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s tag=%0d got=%h expected=%h", name, tag, act, exp);
    end
  endtask

  typedef struct {
    int               tag;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] ldata;
    logic [WIDTH-1:0] tos;
    logic [WIDTH-1:0] nos;
    logic [DW-1:0]    d;
    logic             err;
  } exp_t;

  exp_t sbq[$];
  int   tag_n = 0;

  // monitor: strobes checked in the accept cycle, registers one cycle later
  initial begin
    exp_t cur;
    bit   pend;
    pend = 0;
    forever begin
      @(negedge i_clk);
      if (i_rst) begin
        pend = 0;
      end else begin
        if (pend) begin
          chk("tos", cur.tag, 32'(o_tos), 32'(cur.tos));
          chk("nos", cur.tag, 32'(o_nos), 32'(cur.nos));
          chk("depth", cur.tag, 32'(o_depth), 32'(cur.d));
          chk("err", cur.tag, 32'(o_err), 32'(cur.err));
          pend = 0;
        end
        if (i_se && o_ready) begin
          if (sbq.size() == 0) begin
            chk("unexpected_accept", -1, 32'd1, 32'd0);
          end else begin
            cur = sbq.pop_front();
            chk("lifo_push", cur.tag, 32'(o_lifo_push), 32'(cur.push));
            chk("lifo_pop", cur.tag, 32'(o_lifo_pop), 32'(cur.pop));
            if (cur.push) chk("lifo_data", cur.tag, 32'(o_lifo_data), 32'(cur.ldata));
            pend = 1;
          end
        end
      end
    end
  end

  bit cnt_en = 0;
  int pop_cnt = 0;
  always @(negedge i_clk) if (cnt_en && !i_rst && o_lifo_pop) pop_cnt++;

  task automatic do_op(input logic [2:0] op, input logic [WIDTH-1:0] data,
                       input logic [WIDTH-1:0] e_tos, input logic [WIDTH-1:0] e_nos,
                       input int e_d, input logic e_err,
                       input logic e_push, input logic e_pop, input logic [WIDTH-1:0] e_ldata);
    exp_t e;
    e.tag = tag_n; e.push = e_push; e.pop = e_pop; e.ldata = e_ldata;
    e.tos = e_tos; e.nos = e_nos; e.d = DW'(e_d); e.err = e_err;
    tag_n++;
    sbq.push_back(e);
    i_op = op; i_data = data; i_se = 1'b1;
    @(posedge i_clk); #1;
    i_se = 1'b0;
  endtask

  // push values 1..n onto an empty stack
  task automatic push_seq(input int n, input logic e_err);
    for (int i = 0; i < n; i++)
      do_op(OP_PUSH, WIDTH'(i+1), WIDTH'(i+1), (i >= 1) ? WIDTH'(i) : '0, i+1, e_err,
            (i >= 2), 1'b0, WIDTH'(i-1));
  endtask

  task automatic check_reset_vals(input int tag);
    chk("rst_ready", tag, 32'(o_ready), 32'd1);
    chk("rst_tos", tag, 32'(o_tos), 32'd0);
    chk("rst_nos", tag, 32'(o_nos), 32'd0);
    chk("rst_depth", tag, 32'(o_depth), 32'd0);
    chk("rst_err", tag, 32'(o_err), 32'd0);
    chk("rst_push", tag, 32'(o_lifo_push), 32'd0);
    chk("rst_pop", tag, 32'(o_lifo_pop), 32'd0);
  endtask

  task automatic pulse_reset();
    @(posedge i_clk); #1;
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
  endtask

  initial begin
    int low;
    #1;
    check_reset_vals(1000);
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    check_reset_vals(1001);

    // basic push / ROT / mixed ops
    do_op(OP_PUSH, 16'h0001, 16'h0001, 16'h0000, 1, 0, 0, 0, 0);
    do_op(OP_PUSH, 16'h0002, 16'h0002, 16'h0001, 2, 0, 0, 0, 0);
    do_op(OP_PUSH, 16'h0003, 16'h0003, 16'h0002, 3, 0, 1, 0, 16'h0001);
    do_op(OP_ROT,  16'h0000, 16'h0001, 16'h0003, 3, 0, 1, 1, 16'h0002);
    @(negedge i_clk);
    chk("lifo_top_after_rot", 1002, 32'(i_lifo_data), 32'h2);
    @(posedge i_clk); #1;
    do_op(OP_SWAP,    16'h0000, 16'h0003, 16'h0001, 3, 0, 0, 0, 0);
    do_op(OP_DROP,    16'h0000, 16'h0001, 16'h0002, 2, 0, 0, 1, 0);
    do_op(OP_DUP,     16'h0000, 16'h0001, 16'h0001, 3, 0, 1, 0, 16'h0002);
    do_op(OP_REPLACE, 16'h0077, 16'h0077, 16'h0001, 3, 0, 0, 0, 0);
    do_op(OP_OVER,    16'h0000, 16'h0001, 16'h0077, 4, 0, 1, 0, 16'h0001);
    do_op(OP_DROP,    16'h0000, 16'h0077, 16'h0001, 3, 0, 0, 1, 0);
    do_op(OP_DROP,    16'h0000, 16'h0001, 16'h0002, 2, 0, 0, 1, 0);
    do_op(OP_DROP,    16'h0000, 16'h0002, 16'h0000, 1, 0, 0, 0, 0);
    do_op(OP_DROP,    16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0, 0);

    // underflow: sticky error, illegal SWAP leaves state alone
    do_op(OP_DROP,  16'h0000, 16'h0000, 16'h0000, 0, 1, 0, 0, 0);
    do_op(OP_PUSH,  16'h00AA, 16'h00AA, 16'h0000, 1, 1, 0, 0, 0);
    do_op(OP_SWAP,  16'h0000, 16'h00AA, 16'h0000, 1, 1, 0, 0, 0);
    do_op(OP_CLEAR, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0, 0);

    // overflow at DEPTH+2
    push_seq(DEPTH+2, 1'b0);
    do_op(OP_PUSH, 16'h0099, 16'd14, 16'd13, 14, 1, 0, 0, 0);
    do_op(OP_SWAP, 16'h0000, 16'd13, 16'd14, 14, 1, 0, 0, 0);
    do_op(OP_DROP, 16'h0000, 16'd14, 16'd12, 13, 1, 0, 1, 0);
    @(negedge i_clk);
    pulse_reset();
    check_reset_vals(1003);

    // CLEAR from depth 8 with the error flag set
    do_op(OP_DROP, 16'h0000, 16'h0000, 16'h0000, 0, 1, 0, 0, 0);
    push_seq(8, 1'b1);
    cnt_en = 1; pop_cnt = 0;
    do_op(OP_CLEAR, 16'h0000, 16'h0000, 16'h0000, 8, 0, 0, 1, 0);
    low = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge i_clk);
      if (o_ready) break;
      low++;
    end
    cnt_en = 0;
    chk("drain_low_cycles", 1004, 32'(low), 32'd6);
    chk("drain_pops", 1005, 32'(pop_cnt), 32'd6);
    chk("clear_ready", 1006, 32'(o_ready), 32'd1);
    chk("clear_depth", 1006, 32'(o_depth), 32'd0);
    chk("clear_tos", 1006, 32'(o_tos), 32'd0);
    chk("clear_nos", 1006, 32'(o_nos), 32'd0);
    chk("clear_err", 1006, 32'(o_err), 32'd0);
    chk("clear_lifo_empty", 1006, 32'(i_lifo_empty), 32'd1);
    @(posedge i_clk); #1;

    // async reset in the middle of a drain
    push_seq(8, 1'b0);
    do_op(OP_CLEAR, 16'h0000, 16'h0000, 16'h0000, 8, 0, 0, 1, 0);
    @(posedge i_clk); #2;
    chk("drain_active", 1007, 32'(o_ready), 32'd0);
    i_rst = 1'b1;
    #1;
    check_reset_vals(1008);
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    check_reset_vals(1009);
    do_op(OP_PUSH, 16'h0055, 16'h0055, 16'h0000, 1, 0, 0, 0, 0);
    @(negedge i_clk);
    @(negedge i_clk);
    chk("scoreboard_drained", 1010, 32'(sbq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/stack_cache.md
Name: stack_cache

Overview:
- Data-stack front end that sits directly upstream of the single-ended LIFO (lifo_se) in the fomu CPU.
- Holds the top two stack items (TOS, NOS) in registers and spills deeper items to the LIFO and refills from it.
- Executes one stack operation per cycle, plus a multi-cycle CLEAR that drains the LIFO.
- Presents TOS, NOS, depth and a sticky error flag to the CPU datapath.

Parameters:
- WIDTH, 16, data word width in bits.
- DEPTH, 12, capacity of the attached LIFO. Total stack capacity is DEPTH+2.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_rst  in  1  asynchronous active-high reset.
- i_se  in  1  operation strobe; sampled only when o_ready=1.
- i_op  in  3  operation code: 0 CLEAR, 1 PUSH, 2 DROP, 3 DUP, 4 SWAP, 5 OVER, 6 ROT, 7 REPLACE.
- i_data  in  WIDTH  operand for PUSH and REPLACE.
- o_ready  out  1  high when a new op can be accepted.
- o_tos  out  WIDTH  top of stack, registered.
- o_nos  out  WIDTH  next on stack, registered.
- o_depth  out  $clog2(DEPTH+3)  total item count, 0..DEPTH+2.
- o_err  out  1  sticky underflow/overflow flag.
- o_lifo_push  out  1  push strobe to LIFO.
- o_lifo_pop  out  1  pop strobe to LIFO. Push and pop in the same cycle means replace the LIFO top.
- o_lifo_data  out  WIDTH  data to push.
- i_lifo_data  in  WIDTH  current LIFO top; valid when i_lifo_empty=0.
- i_lifo_empty  in  1  LIFO empty.
- i_lifo_full  in  1  LIFO full.

Behaviour:
- Reset values:
  - State READY; o_ready=1.
  - o_tos=0, o_nos=0, o_depth=0, o_err=0.
  - o_lifo_push=0, o_lifo_pop=0.
  - The LIFO shares i_rst, so it is also empty after reset.
- LIFO strobes are combinational from the accepted op and current state. Every other output is registered and updates on the clock edge that accepts the op, i.e. 1-cycle latency.
- Notation: d = o_depth; L = LIFO top.
- Op requirements (minimum items needed, else underflow):
  - PUSH needs d<DEPTH+2, else overflow.
  - DROP and REPLACE need d>=1.
  - DUP needs d>=1 and d<DEPTH+2.
  - SWAP needs d>=2.
  - OVER needs 2<=d<DEPTH+2.
  - ROT needs d>=3.
- Illegal op: state unchanged, no LIFO strobes, o_err<=1. o_err holds until CLEAR completes or reset.
- PUSH:
  - TOS<=i_data; NOS<=TOS; d+1.
  - If d>=2: push NOS to LIFO.
- DROP:
  - TOS<=NOS; d-1.
  - If d>=3: NOS<=L and pop.
  - If d<=2: NOS<=0.
- DUP: as PUSH with i_data replaced by TOS.
- OVER: as PUSH with i_data replaced by NOS.
- SWAP: TOS<=>NOS; no LIFO access.
- ROT (a b c -- b c a), with a=L, b=NOS, c=TOS:
  - TOS<=L; NOS<=TOS.
  - LIFO replace: push NOS with pop in the same cycle.
  - d unchanged.
- REPLACE: TOS<=i_data only.
- Invalid registers: when d<2 the unused register(s) read 0. SWAP/OVER/ROT never expose stale values because of the depth checks.
- CLEAR state machine:
  - Accepting CLEAR: TOS<=0, NOS<=0, o_err<=0.
  - If i_lifo_empty: d<=0, stay READY (1 cycle).
  - Otherwise go to DRAIN with o_ready=0. Each DRAIN cycle asserts o_lifo_pop.
  - Return to READY, with d<=0, on the cycle i_lifo_empty is seen high.
  - i_se is ignored in DRAIN.
- Consistency check: i_lifo_full while pushing with pop low should not occur given depth tracking. If it does, the push is suppressed and o_err<=1.
- Async reset mid-DRAIN or mid-op: immediate return to reset values, with no LIFO strobes.

Test Plan:
- Reset, then PUSH 0x0001, 0x0002, 0x0003 -> TOS=3, NOS=2, d=3; one o_lifo_push with data 0x0001 on the third push.
- From state 1,2,3, ROT -> TOS=1, NOS=3, d=3, LIFO top=2; push and pop asserted in the same cycle.
- Push DEPTH+2 values, then one more PUSH -> suppressed, d=DEPTH+2, o_err=1 and remains 1 across subsequent legal ops.
- Empty stack, DROP -> o_err=1, d=0, TOS=0; then PUSH 0x00AA, SWAP -> o_err stays 1, state unchanged.
- Depth 8, CLEAR -> o_ready low for exactly 6 cycles with 6 pops; then o_ready=1, d=0, TOS=NOS=0, o_err=0.
- Assert i_rst for one cycle during DRAIN -> all outputs at reset values immediately; next PUSH 0x0055 gives TOS=0x55, d=1.
